// File: rtl/serial_frame_rx.sv
`timescale 1ns/1ps
// serial_frame_rx
// ---------------------------------------------------------------------------
// Receiver for the single-wire serial link between sibling instances. It
// deframes start / channel / data / stop sequences into a 2-bit channel tag
// and a DATA_W-bit payload, and holds each good frame on a valid/ready port.
//
// Frame on the line, first bit first:
//   start (0), 2 channel bits LSB first, DATA_W data bits LSB first,
//   [even-parity bit], stop (1)
//
// Build option:
//   SERIAL_FRAME_RX_PARITY_CHECK_EN  when defined, a parity bit follows the
//   data bits. The XOR of the channel bits, the data bits and the parity bit
//   must be 0, otherwise the frame is rejected at the stop sample.
//
// Parameters:
//   DATA_W  payload bits per frame (1..32)
//   CNT_W   bit-counter width, 2**CNT_W > DATA_W+2
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   sin          serial line, idles high
//   bit_en       sample strobe; sin is only looked at when this is high
//   frame_ready  consumer accepts the held frame
//   frame_valid  frame_chan / frame_data hold a good frame
//   frame_chan   channel tag of the held frame
//   frame_data   payload of the held frame
//   frame_err    one-cycle pulse on a framing (or parity) error
//   overrun      one-cycle pulse when a good frame is dropped
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              bit_en,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [1:0]        frame_chan,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHAN    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  localparam logic [CNT_W-1:0] CHAN_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  count;
  logic [1:0]        chan_sh;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] data_next;
  logic              parity_ok;
  logic              stop_edge;
  logic              stop_good;
  logic              take;

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  logic par_acc;
  logic par_bit;
`endif

  // Data arrives LSB first, so each new bit enters at the top and the word
  // shifts down; after DATA_W samples the first bit sits in bit 0. Written
  // as a loop so DATA_W=1 needs no special-case slice.
  always_comb begin
    data_next = data_sh;
    for (int i = 0; i < DATA_W - 1; i++) begin
      data_next[i] = data_sh[i+1];
    end
    data_next[DATA_W-1] = sin;
  end

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
  assign parity_ok = ~(par_acc ^ par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // Decisions taken on the edge that samples the stop bit. A good frame is
  // loaded if the output slot is empty or is being emptied on this edge.
  assign stop_edge = (state == S_STOP) && bit_en;
  assign stop_good = stop_edge && sin && parity_ok;
  assign take      = stop_good && (!frame_valid || frame_ready);

  // Deframing FSM: only moves on strobed edges, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      chan_sh <= '0;
      data_sh <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
      par_acc <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else if (bit_en) begin
      case (state)
        S_IDLE: begin
          if (!sin) begin
            state <= S_CHAN;
            count <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
            par_acc <= 1'b0;
`endif
          end
        end
        S_CHAN: begin
          chan_sh <= {sin, chan_sh[1]};
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
          par_acc <= par_acc ^ sin;
`endif
          if (count == CHAN_LAST) begin
            count <= '0;
            state <= S_DATA;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_DATA: begin
          data_sh <= data_next;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
          par_acc <= par_acc ^ sin;
`endif
          if (count == DATA_LAST) begin
            count <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end else begin
            count <= count + CNT_W'(1);
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
        S_PARITY: begin
          par_bit <= sin;
          state   <= S_STOP;
        end
`endif
        S_STOP: begin
          if (sin && parity_ok) begin
            state <= S_IDLE;
          end else begin
            state <= S_WAIT_HI;
          end
        end
        // A line stuck low after a bad frame must not look like a run of
        // start bits, so wait for it to return high first.
        S_WAIT_HI: begin
          if (sin) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output slot and status pulses. Pulses are cleared every clock so they
  // are exactly one cycle wide regardless of bit_en. A commit on the same
  // edge as a transfer keeps frame_valid high with the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_chan  <= '0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= stop_edge && !stop_good;
      overrun   <= stop_good && !take;
      if (take) begin
        frame_valid <= 1'b1;
        frame_chan  <= chan_sh;
        frame_data  <= data_sh;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
`timescale 1ns/1ps
// tb_serial_frame_rx
// Drives whole frames onto sin from a bit-level description built by the
// bench, tags the stop-bit sample of every frame as good or bad, and keeps a
// frame-level model of the output slot (hold / accept / drop) that is
// compared against the DUT on every clock. Directed cases pin the model with
// literal values; a randomized phase follows.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 6;

  localparam int MK_NONE = 0;
  localparam int MK_GOOD = 1;
  localparam int MK_BAD  = 2;

  localparam int K_GOOD    = 0;
  localparam int K_BADSTOP = 1;
  localparam int K_BADPAR  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sin = 1'b1;
  logic              bitEn = 1'b0;
  logic              frameReady = 1'b0;
  logic              frameValid;
  logic [1:0]        frameChan;
  logic [DATA_W-1:0] frameData;
  logic              frameErr;
  logic              overrun;

  // Stop-sample tag and the content of the frame currently on the line.
  int                markSig = MK_NONE;
  logic [1:0]        lineChan = '0;
  logic [DATA_W-1:0] lineData = '0;

  // Stimulus pacing.
  int gap = 0;
  bit randGap = 1'b0;
  bit randReady = 1'b0;

  // Frame-level model of the output port.
  logic              expValid = 1'b0;
  logic [1:0]        expChan = '0;
  logic [DATA_W-1:0] expData = '0;
  logic              expErr = 1'b0;
  logic              expOvr = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  serial_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .bit_en     (bitEn),
    .frame_ready(frameReady),
    .frame_valid(frameValid),
    .frame_chan (frameChan),
    .frame_data (frameData),
    .frame_err  (frameErr),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // One clock; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) frameReady = 1'($urandom_range(0, 1));
  endtask

  // Present one bit with bit_en for exactly one edge, after a number of
  // unstrobed cycles. Returns 1 ns after the sampling edge.
  task automatic applyStimulus(input logic b, input int mark, input bit rdyPulse);
    int g;
    g = randGap ? int'($urandom_range(0, 3)) : gap;
    repeat (g) tick();
    sin     = b;
    bitEn   = 1'b1;
    markSig = mark;
    if (rdyPulse) frameReady = 1'b1;
    tick();
    bitEn   = 1'b0;
    markSig = MK_NONE;
    if (rdyPulse) frameReady = 1'b0;
  endtask

  task automatic sendFrame(input logic [1:0] ch, input logic [DATA_W-1:0] d,
                           input int kind, input bit rdyPulse);
    logic par;
    lineChan = ch;
    lineData = d;
    applyStimulus(1'b0, MK_NONE, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(ch[i], MK_NONE, 1'b0);
    for (int i = 0; i < DATA_W; i++) applyStimulus(d[i], MK_NONE, 1'b0);
    par = ^{ch, d};
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    if (kind == K_BADPAR) par = ~par;
    applyStimulus(par, MK_NONE, 1'b0);
`endif
    if (kind == K_BADSTOP)     applyStimulus(1'b0, MK_BAD, rdyPulse);
    else if (kind == K_BADPAR) applyStimulus(1'b1, MK_BAD, rdyPulse);
    else                       applyStimulus(1'b1, MK_GOOD, rdyPulse);
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, MK_NONE, 1'b0);
  endtask

  task automatic checkSlot(input string tag, input logic v, input logic [1:0] c,
                           input logic [DATA_W-1:0] d, input logic e, input logic o);
    checkOutput({tag, ".valid"},   32'(frameValid), 32'(v));
    checkOutput({tag, ".chan"},    32'(frameChan),  32'(c));
    checkOutput({tag, ".data"},    32'(frameData),  32'(d));
    checkOutput({tag, ".err"},     32'(frameErr),   32'(e));
    checkOutput({tag, ".overrun"}, 32'(overrun),    32'(o));
  endtask

  initial begin
    // Model + per-cycle compare. The model reads the inputs at the edge
    // (they only change 1 ns later) and the outputs are compared 1 ns after.
    fork
      forever begin
        @(posedge clk);
        if (reset) begin
          expValid = 1'b0;
          expChan  = '0;
          expData  = '0;
          expErr   = 1'b0;
          expOvr   = 1'b0;
        end else begin
          expErr = bitEn && (markSig == MK_BAD);
          expOvr = 1'b0;
          if (bitEn && (markSig == MK_GOOD)) begin
            if (!expValid || frameReady) begin
              expValid = 1'b1;
              expChan  = lineChan;
              expData  = lineData;
            end else begin
              expOvr = 1'b1;
            end
          end else if (expValid && frameReady) begin
            expValid = 1'b0;
          end
        end
        #1;
        checkOutput("cyc.valid",   32'(frameValid), 32'(expValid));
        checkOutput("cyc.err",     32'(frameErr),   32'(expErr));
        checkOutput("cyc.overrun", 32'(overrun),    32'(expOvr));
        if (reset || expValid) begin
          checkOutput("cyc.chan", 32'(frameChan), 32'(expChan));
          checkOutput("cyc.data", 32'(frameData), 32'(expData));
        end
      end
    join_none

    // Reset state.
    repeat (3) tick();
    checkSlot("reset", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Basic frame, strobe every cycle.
    frameReady = 1'b1;
    gap = 0;
    sendFrame(2'b10, 8'hA5, K_GOOD, 1'b0);
    checkSlot("t1", 1'b1, 2'b10, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("t1.drop", 32'(frameValid), 32'd0);
    idleBits(2);

    // Same frame, strobe every 4th cycle.
    gap = 3;
    sendFrame(2'b10, 8'hA5, K_GOOD, 1'b0);
    checkSlot("t2", 1'b1, 2'b10, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("t2.drop", 32'(frameValid), 32'd0);
    gap = 0;
    idleBits(2);

    // Stop bit low, line held low, then high; next good frame gets through.
    sendFrame(2'b11, 8'h77, K_BADSTOP, 1'b0);
    checkOutput("t3.err", 32'(frameErr), 32'd1);
    checkOutput("t3.valid", 32'(frameValid), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, MK_NONE, 1'b0);
    idleBits(1);
    sendFrame(2'b01, 8'h3C, K_GOOD, 1'b0);
    checkSlot("t3b", 1'b1, 2'b01, 8'h3C, 1'b0, 1'b0);
    idleBits(2);

    // Overrun: consumer stalled.
    frameReady = 1'b0;
    sendFrame(2'b00, 8'h11, K_GOOD, 1'b0);
    checkSlot("t4a", 1'b1, 2'b00, 8'h11, 1'b0, 1'b0);
    idleBits(1);
    sendFrame(2'b00, 8'h22, K_GOOD, 1'b0);
    checkSlot("t4b", 1'b1, 2'b00, 8'h11, 1'b0, 1'b1);
    tick();
    checkOutput("t4b.pulse", 32'(overrun), 32'd0);
    idleBits(1);
    // Ready on the stop edge: replace rather than drop.
    sendFrame(2'b00, 8'h22, K_GOOD, 1'b1);
    checkSlot("t4c", 1'b1, 2'b00, 8'h22, 1'b0, 1'b0);
    idleBits(1);

    // Reset in the middle of a frame while a frame is still held.
    sendFrame(2'b11, 8'h5A, K_GOOD, 1'b0);
    applyStimulus(1'b0, MK_NONE, 1'b0);
    applyStimulus(1'b0, MK_NONE, 1'b0);
    applyStimulus(1'b0, MK_NONE, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, MK_NONE, 1'b0);
    #2;
    reset = 1'b1;
    tick();
    checkSlot("t5.rst", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    tick();
    frameReady = 1'b1;
    idleBits(2);
    sendFrame(2'b01, 8'hFF, K_GOOD, 1'b0);
    checkSlot("t5", 1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
    idleBits(2);

`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
    // chan=11, data=01: three ones, so the parity bit is 1.
    sendFrame(2'b11, 8'h01, K_GOOD, 1'b0);
    checkSlot("t6a", 1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
    idleBits(2);
    sendFrame(2'b11, 8'h01, K_BADPAR, 1'b0);
    checkSlot("t6b", 1'b0, 2'b11, 8'h01, 1'b1, 1'b0);
    idleBits(2);
`endif

    // Randomized traffic: random strobe spacing, random consumer.
    randGap = 1'b1;
    randReady = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int kind;
      int r;
      r = int'($urandom_range(0, 9));
      kind = K_GOOD;
      if (r == 0) kind = K_BADSTOP;
`ifdef SERIAL_FRAME_RX_PARITY_CHECK_EN
      if (r == 1) kind = K_BADPAR;
`endif
      sendFrame(2'($urandom), DATA_W'($urandom), kind, 1'b0);
      if (kind == K_BADSTOP) begin
        int lo;
        lo = int'($urandom_range(0, 5));
        for (int i = 0; i < lo; i++) applyStimulus(1'b0, MK_NONE, 1'b0);
      end
      if (kind != K_GOOD) idleBits(int'($urandom_range(1, 3)));
      else                idleBits(int'($urandom_range(0, 2)));
    end

    randGap = 1'b0;
    randReady = 1'b0;
    frameReady = 1'b1;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
